// File: rtl/data_mem_arbiter.sv
// Data memory port arbiter: the pipeline MEM stage and a DMA/debug requester
// share one single-port data memory. The pipeline normally wins. A starvation
// counter forces a DMA grant, which stalls the pipeline for that cycle.
// DMA read data is returned through a registered valid/ready response.
module data_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 3
) (
  input  logic              clk,
  input  logic              reset,
  // pipeline MEM stage side
  input  logic              pipe_MemRead,
  input  logic              pipe_MemWrite,
  input  logic [ADDR_W-1:0] pipe_Address,
  input  logic [DATA_W-1:0] pipe_Write_data,
  output logic              pipe_stall,
  // DMA request channel
  input  logic              dma_req_valid,
  input  logic              dma_req_write,
  input  logic [ADDR_W-1:0] dma_req_addr,
  input  logic [DATA_W-1:0] dma_req_wdata,
  output logic              dma_req_ready,
  // DMA response channel
  output logic              dma_rsp_valid,
  output logic [DATA_W-1:0] dma_rsp_data,
  input  logic              dma_rsp_ready,
  // data memory side
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] mem_Address,
  output logic [DATA_W-1:0] mem_Write_data,
  input  logic [DATA_W-1:0] mem_Read_data
);

  typedef enum logic {
    ST_OPEN = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_nxt;

  logic pipe_req;
  logic dma_elig;
  logic starve_due;
  logic dma_grant;
  logic rsp_capture;
  logic rsp_done;

  // Counter increment that holds at the forced-grant threshold.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (cnt >= WAIT_LIMIT) return WAIT_LIMIT;
    return cnt + CNT_W'(1);
  endfunction

  assign pipe_req    = pipe_MemRead | pipe_MemWrite;
  // Reset gates eligibility so no grant or stall is ever seen while in reset.
  assign dma_elig    = dma_req_valid & (state == ST_OPEN) & ~reset;
  assign starve_due  = (starve_cnt == WAIT_LIMIT);
  assign dma_grant   = dma_elig & (~pipe_req | starve_due);
  assign rsp_capture = dma_grant & ~dma_req_write;
  assign rsp_done    = dma_rsp_valid & dma_rsp_ready;

  // State register: tracks whether a DMA read response is outstanding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_OPEN;
    else       state <= state_nxt;
  end

  // Next-state logic: reads open a response window, consumer handshake closes it.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_OPEN: if (rsp_capture) state_nxt = ST_RESP;
      ST_RESP: if (rsp_done)    state_nxt = ST_OPEN;
      default: state_nxt = ST_OPEN;
    endcase
  end

  // Output logic: memory port mux, grant and stall.
  always_comb begin
    dma_req_ready  = dma_grant;
    pipe_stall     = dma_grant & pipe_req;
    MemRead        = pipe_MemRead;
    MemWrite       = pipe_MemWrite;
    mem_Address    = pipe_Address;
    mem_Write_data = pipe_Write_data;
    if (dma_grant) begin
      MemRead        = ~dma_req_write;
      MemWrite       = dma_req_write;
      mem_Address    = dma_req_addr;
      mem_Write_data = dma_req_wdata;
    end
  end

  // Starvation count: lost cycles of a continuously pending DMA request,
  // also accumulated while a response is outstanding.
  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (~dma_req_valid | dma_grant) starve_cnt_nxt = '0;
    else                            starve_cnt_nxt = sat_inc(starve_cnt);
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) starve_cnt <= '0;
    else       starve_cnt <= starve_cnt_nxt;
  end

  // Response register: capture read data on a read grant, hold until consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dma_rsp_valid <= 1'b0;
      dma_rsp_data  <= '0;
    end else begin
      if (rsp_done)    dma_rsp_valid <= 1'b0;
      if (rsp_capture) begin
        dma_rsp_valid <= 1'b1;
        dma_rsp_data  <= mem_Read_data;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed table, hand-written
// multi-cycle sequences, then randomized traffic against a transaction model.
module tb_data_mem_arbiter;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_MemRead, pipe_MemWrite;
  logic [31:0] pipe_Address, pipe_Write_data;
  logic        pipe_stall;
  logic        dma_req_valid, dma_req_write;
  logic [31:0] dma_req_addr, dma_req_wdata;
  logic        dma_req_ready;
  logic        dma_rsp_valid;
  logic [31:0] dma_rsp_data;
  logic        dma_rsp_ready;
  logic        MemRead, MemWrite;
  logic [31:0] mem_Address, mem_Write_data, mem_Read_data;

  data_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .pipe_MemRead(pipe_MemRead), .pipe_MemWrite(pipe_MemWrite),
    .pipe_Address(pipe_Address), .pipe_Write_data(pipe_Write_data),
    .pipe_stall(pipe_stall),
    .dma_req_valid(dma_req_valid), .dma_req_write(dma_req_write),
    .dma_req_addr(dma_req_addr), .dma_req_wdata(dma_req_wdata),
    .dma_req_ready(dma_req_ready),
    .dma_rsp_valid(dma_rsp_valid), .dma_rsp_data(dma_rsp_data),
    .dma_rsp_ready(dma_rsp_ready),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .mem_Address(mem_Address), .mem_Write_data(mem_Write_data),
    .mem_Read_data(mem_Read_data)
  );

  always #5 clk = ~clk;

  // Memory contents as a pure function of address (combinational read).
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h20) return 32'hDEADBEEF;
    return {a[15:0] ^ 16'h3C5A, ~a[31:16]};
  endfunction

  assign mem_Read_data = mem_word(mem_Address);

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: outstanding response, its data, lost-cycle count.
  bit          m_pend;
  logic [31:0] m_data;
  int          m_lost;
  bit          m_grant;

  task automatic model_clear();
    m_pend = 1'b0;
    m_data = 32'h0;
    m_lost = 0;
  endtask

  task automatic check_model();
    bit preq;
    preq    = pipe_MemRead | pipe_MemWrite;
    m_grant = !reset && dma_req_valid && !m_pend && (!preq || m_lost >= MAX_WAIT);
    chk("m_memread",  32'(MemRead),  32'(m_grant ? !dma_req_write : pipe_MemRead));
    chk("m_memwrite", 32'(MemWrite), 32'(m_grant ? dma_req_write  : pipe_MemWrite));
    chk("m_addr",     mem_Address,    m_grant ? dma_req_addr  : pipe_Address);
    chk("m_wdata",    mem_Write_data, m_grant ? dma_req_wdata : pipe_Write_data);
    chk("m_stall",    32'(pipe_stall),    32'(m_grant && preq));
    chk("m_ready",    32'(dma_req_ready), 32'(m_grant));
    chk("m_rspvalid", 32'(dma_rsp_valid), 32'(m_pend));
    chk("m_rspdata",  dma_rsp_data, m_data);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_clear();
    else begin
      if (m_pend && dma_rsp_ready) m_pend = 1'b0;
      if (m_grant && !dma_req_write) begin
        m_pend = 1'b1;
        m_data = mem_word(dma_req_addr);
      end
      if (!dma_req_valid || m_grant) m_lost = 0;
      else if (m_lost < MAX_WAIT)    m_lost++;
    end
    #1;
  endtask

  task automatic settle();
    #8;
  endtask

  task automatic finish_cycle();
    check_model();
    tick();
  endtask

  task automatic set_idle();
    pipe_MemRead = 0; pipe_MemWrite = 0; pipe_Address = 32'h0; pipe_Write_data = 32'h0;
    dma_req_valid = 0; dma_req_write = 0; dma_req_addr = 32'h0; dma_req_wdata = 32'h0;
    dma_rsp_ready = 0;
  endtask

  // Reset for one edge with a DMA request present: no grant may appear.
  task automatic do_reset();
    set_idle();
    dma_req_valid = 1;
    reset = 1;
    model_clear();
    settle();
    chk("rst_ready",    32'(dma_req_ready), 32'h0);
    chk("rst_stall",    32'(pipe_stall),    32'h0);
    chk("rst_rspvalid", 32'(dma_rsp_valid), 32'h0);
    chk("rst_rspdata",  dma_rsp_data,       32'h0);
    m_grant = 1'b0;
    tick();
    reset = 0;
    set_idle();
  endtask

  // Pipe requesting every cycle, DMA valid: four losses, forced grant on the fifth.
  task automatic starve_run(input logic wr, input logic [31:0] addr);
    for (int i = 0; i < 5; i++) begin
      pipe_MemRead = 1; pipe_Address = 32'h100 + 32'(i);
      dma_req_valid = 1; dma_req_write = wr; dma_req_addr = addr; dma_req_wdata = 32'hC0DE0000 + 32'(i);
      settle();
      chk("starve_ready", 32'(dma_req_ready), 32'(i == 4));
      chk("starve_stall", 32'(pipe_stall),    32'(i == 4));
      finish_cycle();
    end
  endtask

  typedef struct {
    logic        prd, pwr;
    logic [31:0] paddr, pwdata;
    logic        dv, dw;
    logic [31:0] daddr, dwdata;
    logic        e_rd, e_wr;
    logic [31:0] e_addr, e_wdata;
    logic        e_stall, e_ready, e_rv;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t tbl[6];

  initial begin
    // pipe load only
    tbl[0] = '{1, 0, 32'h10, 32'h0,  0, 0, 32'h0,  32'h0,        1, 0, 32'h10, 32'h0,        0, 0, 0, 32'h0};
    // pipe idle, DMA read of 0x20
    tbl[1] = '{0, 0, 32'h0,  32'h0,  1, 0, 32'h20, 32'h0,        1, 0, 32'h20, 32'h0,        0, 1, 1, 32'hDEADBEEF};
    // pipe store beats DMA read
    tbl[2] = '{0, 1, 32'h44, 32'h1234, 1, 0, 32'h20, 32'h0,      0, 1, 32'h44, 32'h1234,     0, 0, 0, 32'h0};
    // nobody requests: strobes low, pipe address/data pass through
    tbl[3] = '{0, 0, 32'h88, 32'h77, 0, 0, 32'h99, 32'h66,       0, 0, 32'h88, 32'h77,       0, 0, 0, 32'h0};
    // DMA write, pipe idle
    tbl[4] = '{0, 0, 32'h0,  32'h0,  1, 1, 32'h30, 32'h5A5A5A5A, 0, 1, 32'h30, 32'h5A5A5A5A, 0, 1, 0, 32'h0};
    // pipe load beats DMA write
    tbl[5] = '{1, 0, 32'h14, 32'h0,  1, 1, 32'h30, 32'h5A5A5A5A, 1, 0, 32'h14, 32'h0,        0, 0, 0, 32'h0};

    reset = 1;
    set_idle();

    // Directed single-transaction vectors, each from a fresh reset.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      pipe_MemRead = tbl[i].prd; pipe_MemWrite = tbl[i].pwr;
      pipe_Address = tbl[i].paddr; pipe_Write_data = tbl[i].pwdata;
      dma_req_valid = tbl[i].dv; dma_req_write = tbl[i].dw;
      dma_req_addr = tbl[i].daddr; dma_req_wdata = tbl[i].dwdata;
      settle();
      chk("tbl_memread",  32'(MemRead),       32'(tbl[i].e_rd));
      chk("tbl_memwrite", 32'(MemWrite),      32'(tbl[i].e_wr));
      chk("tbl_addr",     mem_Address,        tbl[i].e_addr);
      chk("tbl_wdata",    mem_Write_data,     tbl[i].e_wdata);
      chk("tbl_stall",    32'(pipe_stall),    32'(tbl[i].e_stall));
      chk("tbl_ready",    32'(dma_req_ready), 32'(tbl[i].e_ready));
      finish_cycle();
      chk("tbl_rspvalid", 32'(dma_rsp_valid), 32'(tbl[i].e_rv));
      chk("tbl_rspdata",  dma_rsp_data,       tbl[i].e_rdata);
    end

    // Starvation with writes: forced grant, counter restarts, forced again.
    do_reset();
    starve_run(1'b1, 32'h40);
    starve_run(1'b1, 32'h44);

    // Held response blocks a second read until consumed; no same-cycle re-grant.
    do_reset();
    dma_req_valid = 1; dma_req_write = 0; dma_req_addr = 32'h20;
    settle();
    chk("hold_first_ready", 32'(dma_req_ready), 32'h1);
    finish_cycle();
    dma_req_addr = 32'h50;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("hold_rspvalid", 32'(dma_rsp_valid), 32'h1);
      chk("hold_rspdata",  dma_rsp_data,       32'hDEADBEEF);
      chk("hold_ready",    32'(dma_req_ready), 32'h0);
      finish_cycle();
    end
    dma_rsp_ready = 1;
    settle();
    chk("take_ready",    32'(dma_req_ready), 32'h0);
    chk("take_rspvalid", 32'(dma_rsp_valid), 32'h1);
    finish_cycle();
    dma_rsp_ready = 0;
    settle();
    chk("regrant_rspvalid", 32'(dma_rsp_valid), 32'h0);
    chk("regrant_ready",    32'(dma_req_ready), 32'h1);
    chk("regrant_addr",     mem_Address,        32'h50);
    finish_cycle();
    dma_req_valid = 0;
    settle();
    chk("second_rspvalid", 32'(dma_rsp_valid), 32'h1);
    chk("second_rspdata",  dma_rsp_data,       mem_word(32'h50));
    finish_cycle();

    // Back-to-back DMA writes with the pipe idle.
    do_reset();
    dma_req_valid = 1; dma_req_write = 1; dma_req_addr = 32'h30; dma_req_wdata = 32'h5A5A5A5A;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("wr_memwrite", 32'(MemWrite),      32'h1);
      chk("wr_ready",    32'(dma_req_ready), 32'h1);
      chk("wr_wdata",    mem_Write_data,     32'h5A5A5A5A);
      chk("wr_rspvalid", 32'(dma_rsp_valid), 32'h0);
      finish_cycle();
    end
    dma_req_valid = 0;
    settle();
    chk("wr_after_rspvalid", 32'(dma_rsp_valid), 32'h0);
    finish_cycle();

    // Async reset mid-cycle while a response is held and starvation has built up.
    do_reset();
    dma_req_valid = 1; dma_req_write = 0; dma_req_addr = 32'h20;
    settle();
    finish_cycle();
    pipe_MemRead = 1; pipe_Address = 32'h200; dma_req_addr = 32'h60;
    for (int i = 0; i < 5; i++) begin
      settle();
      finish_cycle();
    end
    reset = 1;
    #1;
    chk("arst_rspvalid", 32'(dma_rsp_valid), 32'h0);
    chk("arst_rspdata",  dma_rsp_data,       32'h0);
    chk("arst_ready",    32'(dma_req_ready), 32'h0);
    chk("arst_stall",    32'(pipe_stall),    32'h0);
    model_clear();
    #7;
    finish_cycle();
    reset = 0;
    starve_run(1'b1, 32'h64);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      pipe_MemRead    = ($urandom_range(0, 9) < 4);
      pipe_MemWrite   = !pipe_MemRead && ($urandom_range(0, 9) < 3);
      pipe_Address    = $urandom;
      pipe_Write_data = $urandom;
      dma_req_valid   = ($urandom_range(0, 9) < 7);
      dma_req_write   = ($urandom_range(0, 1) == 1);
      dma_req_addr    = {24'h0, 8'($urandom)};
      dma_req_wdata   = $urandom;
      dma_rsp_ready   = ($urandom_range(0, 9) < 4);
      settle();
      finish_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
